hc_tx_port_arbiter_n: RTL and testbench
=======================================

Name: hc_tx_port_arbiter_n

Overview:
Parametrised N-client arbiter for the host-controller Tx port. It grants exclusive use of the shared port (data, control and write-enable bytes toward the SIE transmit side) to one requester at a time. Supported policies are fixed priority, with optional starvation promotion, and round-robin. It generalises the fixed three-client Tx port arbitration so that new requesters can attach without RTL edits. A hold-time watchdog force-releases a client that keeps the port for too long.

Parameters:
N_CLIENTS, 3, number of requesters (2..8); index 0 is highest fixed priority.
DATA_W, 8, width of each data and control byte lane.
RR_MODE, 0, 0 = fixed priority, 1 = round-robin.
STARVE_LIMIT, 0, fixed mode only: wait cycles before a requester is promoted; 0 disables promotion.
MAX_HOLD, 0, maximum consecutive grant cycles before forced release; 0 disables the watchdog.

Ports:
clk  in  1  port clock (usbClk domain).
rst  in  1  asynchronous, active-low reset.
req  in  N_CLIENTS  per-client request, level.
gnt  out  N_CLIENTS  per-client grant, one-hot or zero, registered.
clientWEn  in  N_CLIENTS  per-client write enable.
clientData  in  N_CLIENTS*DATA_W  client i occupies bits [i*DATA_W +: DATA_W].
clientCntl  in  N_CLIENTS*DATA_W  same packing as clientData.
HCTxPortWEnable  out  1  registered write enable toward the Tx port.
HCTxPortData  out  DATA_W  registered muxed data.
HCTxPortCntl  out  DATA_W  registered muxed control.
holdViolation  out  1  one-cycle pulse when the watchdog forces a release.

Behaviour:
- Reset (rst low, asynchronous): gnt=0, HCTxPortWEnable=0, HCTxPortData=0, HCTxPortCntl=0, holdViolation=0, state=IDLE, RR pointer=N_CLIENTS-1, all wait and hold counters=0.
- States: IDLE and GRANT(owner).
- IDLE: if req≠0 at an edge, pick a winner, set gnt[winner]=1 and go to GRANT. Grant latency is 1 cycle from the first sampled req.
- Winner selection, fixed mode: lowest index with waitCnt==STARVE_LIMIT (when STARVE_LIMIT>0), otherwise lowest index with req set.
- Winner selection, RR mode: first req at or after (ptr+1) mod N_CLIENTS. On grant, ptr=winner.
- GRANT: gnt holds while req[owner]=1.
  - An edge that samples req[owner]=0 clears gnt and returns to IDLE.
  - At least one cycle with gnt=0 separates consecutive grants, so there are no back-to-back grants.
- Wait counters (fixed mode, STARVE_LIMIT>0):
  - waitCnt[i] increments each cycle that req[i]=1 and gnt[i]=0, saturating at STARVE_LIMIT.
  - It clears when gnt[i] is set or req[i]=0.
  - Counter width is clog2(STARVE_LIMIT+1).
  - RR mode ignores the counters.
- Output mux:
  - In GRANT, each edge registers HCTxPortData/Cntl ← clientData/Cntl[owner] and HCTxPortWEnable ← clientWEn[owner].
  - In IDLE the registered outputs are 0.
  - clientWEn from non-owners is ignored entirely.
  - Mux latency is 1 cycle.
- Watchdog (MAX_HOLD>0):
  - holdCnt counts cycles in GRANT.
  - When holdCnt reaches MAX_HOLD with req[owner] still high: gnt clears, state goes to IDLE, holdViolation pulses for 1 cycle, and HCTxPortWEnable=0 on the next edge.
  - The forced client may re-win in a later arbitration. In fixed mode it is not penalised; in RR mode the pointer has already advanced past it.
- Simultaneous events:
  - req[owner] falling on the same edge as the watchdog expiry is a normal release with no holdViolation.
  - New requests arriving during GRANT wait, and their waitCnt accumulates.
- Reset mid-grant: all outputs drop asynchronously and no partial byte is flagged.

Test Plan:
1. N=3, fixed mode: req=3'b110 -> one cycle later gnt=3'b010; drop req[1] -> gnt=0 for 1 cycle, then gnt=3'b100.
2. Mux: owner=2, clientWEn[2]=1 with clientData[2]=8'hA5, clientCntl[2]=8'h3C, while clientWEn[0]=1 -> next cycle HCTxPortWEnable=1, Data=A5, Cntl=3C; client 0's byte never appears.
3. RR mode, all req held high, each owner releases after 2 cycles -> grant order 0,1,2,0 with one idle cycle between grants.
4. Fixed mode, STARVE_LIMIT=4: client 0 re-requests continuously and client 2 waits -> client 2 is granted at the first arbitration after waitCnt[2] reaches 4, ahead of client 0.
5. MAX_HOLD=5, client 1 holds req -> gnt[1] clears after 5 grant cycles, holdViolation pulses once, and HCTxPortWEnable=0 on the following edge.
6. Assert rst low mid-grant with WEn active -> gnt, WEnable, Data and Cntl are 0 immediately; after release, the first arbitration in RR mode starts from client 0.

Source files
------------

// File: rtl/hc_tx_port_arbiter_n_if.sv
// hc_tx_port_arbiter_n_if
// Bundle of signals between the N-client Tx port arbiter and its clients.
// Ports (signals):
//   req[N]            per-client request level (client -> arbiter)
//   clientWEn[N]      per-client write enable (client -> arbiter)
//   clientData/Cntl   per-client byte lanes, client i at [i*DATA_W +: DATA_W]
//   gnt[N]            registered one-hot-or-zero grant (arbiter -> client)
//   HCTxPort*         registered muxed write enable / data / control toward the SIE
//   holdViolation     one-cycle pulse on a watchdog forced release
//   dbgState/dbgOwner current arbiter state (0 = IDLE, 1 = GRANT) and owner index
//
// Handshake: a client raises req and keeps it high for as long as it wants the
// port. The cycle after the arbiter samples req it may assert gnt; while gnt is
// high the client's WEn/Data/Cntl lanes are registered onto the port one cycle
// later. The client ends its tenure by dropping req; the arbiter may also end it
// early (holdViolation). There is always at least one idle cycle between grants.
interface hc_tx_port_arbiter_n_if #(
  parameter int N_CLIENTS = 3,
  parameter int DATA_W    = 8
);
  localparam int IDX_W = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;

  logic [N_CLIENTS-1:0]        req;
  logic [N_CLIENTS-1:0]        gnt;
  logic [N_CLIENTS-1:0]        clientWEn;
  logic [N_CLIENTS*DATA_W-1:0] clientData;
  logic [N_CLIENTS*DATA_W-1:0] clientCntl;
  logic                        HCTxPortWEnable;
  logic [DATA_W-1:0]           HCTxPortData;
  logic [DATA_W-1:0]           HCTxPortCntl;
  logic                        holdViolation;
  logic                        dbgState;
  logic [IDX_W-1:0]            dbgOwner;

  modport master (
    input  req, clientWEn, clientData, clientCntl,
    output gnt, HCTxPortWEnable, HCTxPortData, HCTxPortCntl, holdViolation,
           dbgState, dbgOwner
  );

  modport slave (
    output req, clientWEn, clientData, clientCntl,
    input  gnt, HCTxPortWEnable, HCTxPortData, HCTxPortCntl, holdViolation,
           dbgState, dbgOwner
  );
endinterface

// File: rtl/hc_tx_port_arbiter_n.sv
// hc_tx_port_arbiter_n
// Grants exclusive use of the host-controller Tx port to one of N_CLIENTS
// requesters, either by fixed priority (index 0 highest, with optional
// starvation promotion) or round-robin, and registers the owner's byte lanes
// onto the port. A hold watchdog can force a long-holding owner off the port.
// Ports:
//   clk  port clock (usbClk domain)
//   rst  asynchronous active-low reset
//   bus  hc_tx_port_arbiter_n_if.master (req/gnt, client lanes, Tx port, debug)
module hc_tx_port_arbiter_n #(
  parameter int N_CLIENTS    = 3,
  parameter int DATA_W       = 8,
  parameter int RR_MODE      = 0,
  parameter int STARVE_LIMIT = 0,
  parameter int MAX_HOLD     = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  hc_tx_port_arbiter_n_if.master  bus
);
  localparam int IDX_W     = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
  localparam int WAIT_W    = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam int HOLD_W    = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam bit STARVE_EN = (RR_MODE == 0) && (STARVE_LIMIT > 0);
  localparam bit HOLD_EN   = (MAX_HOLD > 0);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t               state, stateNext;
  logic [IDX_W-1:0]     owner, ownerNext;
  logic [IDX_W-1:0]     ptr, ptrNext;
  logic [HOLD_W-1:0]    holdCnt, holdCntNext;
  logic [WAIT_W-1:0]    waitCnt [N_CLIENTS];
  logic [N_CLIENTS-1:0] starved;
  logic [IDX_W-1:0]     winner;
  logic                 winnerValid;
  int                   rrIdx;

  logic [N_CLIENTS-1:0] gntNext;
  logic                 weNext;
  logic [DATA_W-1:0]    dataNext;
  logic [DATA_W-1:0]    cntlNext;
  logic                 violNext;

  assign bus.dbgState = logic'(state);
  assign bus.dbgOwner = owner;

  // A saturated counter only promotes a client that is still requesting, so a
  // client that just withdrew can never be handed the port.
  always_comb begin
    starved = '0;
    for (int i = 0; i < N_CLIENTS; i++) begin
      starved[i] = bus.req[i] && (waitCnt[i] == WAIT_W'(STARVE_LIMIT));
    end
  end

  // Winner selection. Loops scan from the far end so the last hit is the
  // preferred candidate (lowest index, or nearest after the RR pointer).
  always_comb begin
    winner      = '0;
    winnerValid = 1'b0;
    rrIdx       = 0;
    if (RR_MODE != 0) begin
      for (int k = N_CLIENTS; k >= 1; k--) begin
        rrIdx = (int'(ptr) + k) % N_CLIENTS;
        if (bus.req[rrIdx]) begin
          winner      = IDX_W'(rrIdx);
          winnerValid = 1'b1;
        end
      end
    end else begin
      for (int i = N_CLIENTS - 1; i >= 0; i--) begin
        if (bus.req[i]) begin
          winner      = IDX_W'(i);
          winnerValid = 1'b1;
        end
      end
      if (STARVE_EN) begin
        for (int i = N_CLIENTS - 1; i >= 0; i--) begin
          if (starved[i]) winner = IDX_W'(i);
        end
      end
    end
  end

  // Next state and registered-output values.
  always_comb begin
    stateNext   = state;
    ownerNext   = owner;
    ptrNext     = ptr;
    holdCntNext = holdCnt;
    gntNext     = '0;
    weNext      = 1'b0;
    dataNext    = '0;
    cntlNext    = '0;
    violNext    = 1'b0;
    case (state)
      IDLE: begin
        if (winnerValid) begin
          stateNext       = GRANT;
          ownerNext       = winner;
          gntNext[winner] = 1'b1;
          holdCntNext     = HOLD_W'(1);
          if (RR_MODE != 0) ptrNext = winner;
        end
      end
      GRANT: begin
        // The owner's lanes are captured on every edge of its tenure,
        // including the edge on which it releases normally.
        weNext   = bus.clientWEn[owner];
        dataNext = bus.clientData[int'(owner)*DATA_W +: DATA_W];
        cntlNext = bus.clientCntl[int'(owner)*DATA_W +: DATA_W];
        if (!bus.req[owner]) begin
          stateNext   = IDLE;
          holdCntNext = '0;
        end else if (HOLD_EN && (holdCnt == HOLD_W'(MAX_HOLD))) begin
          // Forced release: drop the in-flight byte so nothing partial is
          // written toward the SIE.
          stateNext   = IDLE;
          holdCntNext = '0;
          violNext    = 1'b1;
          weNext      = 1'b0;
          dataNext    = '0;
          cntlNext    = '0;
        end else begin
          gntNext[owner] = 1'b1;
          if (HOLD_EN) holdCntNext = holdCnt + HOLD_W'(1);
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state               <= IDLE;
      owner               <= '0;
      ptr                 <= IDX_W'(N_CLIENTS - 1);
      holdCnt             <= '0;
      bus.gnt             <= '0;
      bus.HCTxPortWEnable <= 1'b0;
      bus.HCTxPortData    <= '0;
      bus.HCTxPortCntl    <= '0;
      bus.holdViolation   <= 1'b0;
    end else begin
      state               <= stateNext;
      owner               <= ownerNext;
      ptr                 <= ptrNext;
      holdCnt             <= holdCntNext;
      bus.gnt             <= gntNext;
      bus.HCTxPortWEnable <= weNext;
      bus.HCTxPortData    <= dataNext;
      bus.HCTxPortCntl    <= cntlNext;
      bus.holdViolation   <= violNext;
    end
  end

  // Starvation counters exist only for fixed priority with promotion enabled.
  generate
    if (STARVE_EN) begin : gWait
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int i = 0; i < N_CLIENTS; i++) waitCnt[i] <= '0;
        end else begin
          for (int i = 0; i < N_CLIENTS; i++) begin
            if (!bus.req[i] || bus.gnt[i] || gntNext[i]) begin
              waitCnt[i] <= '0;
            end else if (waitCnt[i] != WAIT_W'(STARVE_LIMIT)) begin
              waitCnt[i] <= waitCnt[i] + WAIT_W'(1);
            end
          end
        end
      end
    end else begin : gNoWait
      always_comb begin
        for (int i = 0; i < N_CLIENTS; i++) waitCnt[i] = '0;
      end
    end
  endgenerate

endmodule

// File: tb/tb_hc_tx_port_arbiter_n.sv
// tb_hc_tx_port_arbiter_n
// Three arbiter configurations share one random client stimulus stream:
//   0 fixA: N=3, fixed priority, STARVE_LIMIT=4, no watchdog
//   1 rrB : N=3, round-robin, MAX_HOLD=5
//   2 fixC: N=4, fixed priority, no promotion, MAX_HOLD=3
// Each is compared every cycle with a transaction-level reference model.
module tb_hc_tx_port_arbiter_n;
  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  // Shared stimulus, 4 clients wide; 3-client instances use the low lanes.
  logic [3:0]  sReq  = '0;
  logic [3:0]  sWen  = '0;
  logic [31:0] sData = '0;
  logic [31:0] sCntl = '0;

  hc_tx_port_arbiter_n_if #(.N_CLIENTS(3), .DATA_W(8)) busA ();
  hc_tx_port_arbiter_n_if #(.N_CLIENTS(3), .DATA_W(8)) busB ();
  hc_tx_port_arbiter_n_if #(.N_CLIENTS(4), .DATA_W(8)) busC ();

  assign busA.req = sReq[2:0];  assign busA.clientWEn = sWen[2:0];
  assign busA.clientData = sData[23:0];  assign busA.clientCntl = sCntl[23:0];
  assign busB.req = sReq[2:0];  assign busB.clientWEn = sWen[2:0];
  assign busB.clientData = sData[23:0];  assign busB.clientCntl = sCntl[23:0];
  assign busC.req = sReq;  assign busC.clientWEn = sWen;
  assign busC.clientData = sData;  assign busC.clientCntl = sCntl;

  hc_tx_port_arbiter_n #(.N_CLIENTS(3), .DATA_W(8), .RR_MODE(0), .STARVE_LIMIT(4), .MAX_HOLD(0))
    dutA (.clk(clk), .rst(rst), .bus(busA));
  hc_tx_port_arbiter_n #(.N_CLIENTS(3), .DATA_W(8), .RR_MODE(1), .STARVE_LIMIT(0), .MAX_HOLD(5))
    dutB (.clk(clk), .rst(rst), .bus(busB));
  hc_tx_port_arbiter_n #(.N_CLIENTS(4), .DATA_W(8), .RR_MODE(0), .STARVE_LIMIT(0), .MAX_HOLD(3))
    dutC (.clk(clk), .rst(rst), .bus(busC));

  // Observed outputs gathered per configuration.
  logic [3:0] dGnt  [3];
  logic       dWe   [3];
  logic [7:0] dData [3];
  logic [7:0] dCntl [3];
  logic       dViol [3];
  logic       dState[3];

  assign dGnt[0] = {1'b0, busA.gnt};  assign dGnt[1] = {1'b0, busB.gnt};  assign dGnt[2] = busC.gnt;
  assign dWe[0] = busA.HCTxPortWEnable;  assign dWe[1] = busB.HCTxPortWEnable;  assign dWe[2] = busC.HCTxPortWEnable;
  assign dData[0] = busA.HCTxPortData;  assign dData[1] = busB.HCTxPortData;  assign dData[2] = busC.HCTxPortData;
  assign dCntl[0] = busA.HCTxPortCntl;  assign dCntl[1] = busB.HCTxPortCntl;  assign dCntl[2] = busC.HCTxPortCntl;
  assign dViol[0] = busA.holdViolation;  assign dViol[1] = busB.holdViolation;  assign dViol[2] = busC.holdViolation;
  assign dState[0] = busA.dbgState;  assign dState[1] = busB.dbgState;  assign dState[2] = busC.dbgState;

  // Configuration table for the reference model.
  int    cN      [3] = '{3, 3, 4};
  bit    cRr     [3] = '{1'b0, 1'b1, 1'b0};
  int    cStarve [3] = '{4, 0, 0};
  int    cMaxHold[3] = '{0, 5, 3};
  string dName   [3] = '{"fixA", "rrB", "fixC"};

  // Reference model state: owner -1 means the port is free.
  int         mOwner[3];
  int         mAge  [3];
  int         mPtr  [3];
  int         mWait [3][4];
  logic [3:0] mGnt  [3];
  logic       mWe   [3];
  logic [7:0] mData [3];
  logic [7:0] mCntl [3];
  logic       mViol [3];

  int nCompared   = 0;
  int nMismatched = 0;
  int nForced     = 0;
  int nResets     = 0;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic modelReset();
    for (int d = 0; d < 3; d++) begin
      mOwner[d] = -1;
      mAge[d]   = 0;
      mPtr[d]   = cN[d] - 1;
      for (int i = 0; i < 4; i++) mWait[d][i] = 0;
      mGnt[d] = '0;  mWe[d] = 1'b0;  mData[d] = '0;  mCntl[d] = '0;  mViol[d] = 1'b0;
    end
  endtask

  // One clock edge of the port, seen from the clients' point of view.
  task automatic modelStep(input int d);
    int n, win, o, c;
    logic [3:0] oldGnt, newGnt;
    n = cN[d];
    oldGnt = mGnt[d];
    newGnt = '0;
    win = -1;
    mWe[d] = 1'b0;  mData[d] = '0;  mCntl[d] = '0;  mViol[d] = 1'b0;
    if (mOwner[d] < 0) begin
      if (cRr[d]) begin
        for (int k = 1; k <= n; k++) begin
          c = (mPtr[d] + k) % n;
          if (win < 0 && sReq[c]) win = c;
        end
      end else begin
        for (int i = 0; i < n; i++)
          if (win < 0 && cStarve[d] > 0 && sReq[i] && mWait[d][i] == cStarve[d]) win = i;
        for (int i = 0; i < n; i++)
          if (win < 0 && sReq[i]) win = i;
      end
      if (win >= 0) begin
        mOwner[d] = win;
        mAge[d] = 1;
        newGnt[win] = 1'b1;
        if (cRr[d]) mPtr[d] = win;
      end
    end else begin
      o = mOwner[d];
      if (sReq[o] && cMaxHold[d] > 0 && mAge[d] == cMaxHold[d]) begin
        mViol[d] = 1'b1;
        mOwner[d] = -1;
        nForced++;
      end else begin
        mWe[d] = sWen[o];
        mData[d] = sData[o*8 +: 8];
        mCntl[d] = sCntl[o*8 +: 8];
        if (sReq[o]) begin
          mAge[d]++;
          newGnt[o] = 1'b1;
        end else begin
          mOwner[d] = -1;
        end
      end
    end
    if (!cRr[d] && cStarve[d] > 0) begin
      for (int i = 0; i < n; i++) begin
        if (!sReq[i] || oldGnt[i] || newGnt[i]) mWait[d][i] = 0;
        else if (mWait[d][i] < cStarve[d]) mWait[d][i]++;
      end
    end
    mGnt[d] = newGnt;
  endtask

  task automatic compareAll();
    for (int d = 0; d < 3; d++) begin
      checkEq({dName[d], ".gnt"},   32'(dGnt[d]),   32'(mGnt[d]));
      checkEq({dName[d], ".wen"},   32'(dWe[d]),    32'(mWe[d]));
      checkEq({dName[d], ".data"},  32'(dData[d]),  32'(mData[d]));
      checkEq({dName[d], ".cntl"},  32'(dCntl[d]),  32'(mCntl[d]));
      checkEq({dName[d], ".viol"},  32'(dViol[d]),  32'(mViol[d]));
      checkEq({dName[d], ".state"}, 32'(dState[d]), 32'(mOwner[d] >= 0));
    end
  endtask

  task automatic checkAllZero(input string when);
    for (int d = 0; d < 3; d++) begin
      checkEq({when, ".", dName[d], ".gnt"},  32'(dGnt[d]),  32'd0);
      checkEq({when, ".", dName[d], ".wen"},  32'(dWe[d]),   32'd0);
      checkEq({when, ".", dName[d], ".data"}, 32'(dData[d]), 32'd0);
      checkEq({when, ".", dName[d], ".cntl"}, 32'(dCntl[d]), 32'd0);
      checkEq({when, ".", dName[d], ".viol"}, 32'(dViol[d]), 32'd0);
    end
  endtask

  task automatic driveRandom();
    for (int i = 0; i < 4; i++)
      if ($urandom_range(0, 5) == 0) sReq[i] = ~sReq[i];
    sWen  = 4'($urandom);
    sData = $urandom;
    sCntl = $urandom;
  endtask

  initial begin
    modelReset();
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 checkAllZero("reset");
    @(negedge clk) rst = 1'b1;

    for (int cyc = 0; cyc < 6000; cyc++) begin
      @(posedge clk);
      for (int d = 0; d < 3; d++) modelStep(d);
      #1 compareAll();
      driveRandom();
      // Reset in the middle of an active round-robin write, twice per run.
      if (nResets < 2 && cyc > 2000 * (nResets + 1) && mOwner[1] >= 0 && mWe[1]) begin
        #2 rst = 1'b0;
        #1 checkAllZero("midReset");
        modelReset();
        nResets++;
        @(negedge clk) rst = 1'b1;
      end
    end

    checkEq("midResetsSeen", 32'(nResets), 32'd2);
    checkEq("forcedReleasesSeen", 32'(nForced > 0), 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end
endmodule
